microwave_timer_ctrl: RTL
=========================

# microwave_timer_ctrl

Control FSM that sequences the BCD down-counter timer chain (minutes, seconds-tens, seconds-units) in the oven timer path. It collects keypad digits into a 3-digit entry register and loads the counter chain on start. It gates the 1 Hz count enable while cooking and handles pause, door interlock and clear. It signals completion when the chain reaches zero.

## Interface
- DONE_CYCLES, 4, number of cycles `done` stays high after the timer expires (≥1)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low; clock is clk
- key_valid  in  1  one-cycle strobe, keypad digit present
- key_digit  in  4  BCD digit; values >9 ignored
- start  in  1  one-cycle start strobe
- stop_clear  in  1  one-cycle stop/clear strobe
- door_closed  in  1  level; 1 = door closed
- tick  in  1  one-cycle 1 Hz enable strobe
- timer_zero  in  1  level; counter chain reads 0:00
- load  out  1  one-cycle load pulse to counter chain
- load_digits  out  12  {min, sec_tens, sec_units} BCD, equals entry register
- count_enablen  out  1  active-low count enable to counter chain
- magnetron_on  out  1  high while cooking
- done  out  1  completion indicator

## Operation
- States: IDLE, ENTRY, COOK, PAUSE, DONE.
- Input priority within a cycle: stop_clear > start > key_valid.
- IDLE: valid digit shifts into entry (entry <= {entry[7:0], digit}) and moves to ENTRY. Other inputs are ignored.
- ENTRY: valid digit shifts; the oldest digit falls off.
  - stop_clear clears entry and moves to IDLE.
  - start is accepted only if door_closed=1, entry≠0 and sec_tens≤5. It then moves to COOK and asserts load. Otherwise start is ignored.
- COOK:
  - stop_clear or door_closed=0 moves to PAUSE.
  - timer_zero=1 while load=0 moves to DONE.
- PAUSE: start with door_closed=1 moves to COOK without reload (load stays 0). stop_clear clears entry and moves to IDLE. Keys are ignored.
- DONE: done=1 for DONE_CYCLES cycles, then entry is cleared and the FSM moves to IDLE. stop_clear leaves immediately: entry cleared, move to IDLE.
- Keys are ignored in COOK, PAUSE and DONE.
- count_enablen = !(state==COOK && tick && !load), combinational.
- magnetron_on = (state==COOK).

## Timing
- Reset (rst=0 at clk edge): state IDLE, entry 0, load 0, done 0. Outputs are magnetron_on 0, count_enablen 1, load_digits 0.
- Reset mid-cook drops magnetron_on on the next edge. Counter chain contents are left untouched.
- Start accepted at edge N: at N, state becomes COOK and load=1 for exactly one cycle. The counters capture load_digits at edge N+1.
- timer_zero is ignored while load=1. It is valid from cycle N+1 onward.
- In COOK, stop_clear or door open at edge M: state becomes PAUSE at M, so magnetron_on=0 and count_enablen=1 from the cycle after M.
- tick coincident with load is not counted.
- timer_zero and stop_clear in the same COOK cycle: go to PAUSE (stop_clear wins).
- timer_zero rises at edge Z: state becomes DONE at Z; done is high for cycles Z..Z+DONE_CYCLES-1, then the state is IDLE.
- Entry of 0:00, or sec_tens>5 (e.g. 1:75), makes start a no-op; the state remains ENTRY.

## Structure
- Package microwave_pkg holds:
  - state enum (IDLE, ENTRY, COOK, PAUSE, DONE)
  - BCD_MAX=9, SEC_TENS_MAX=5, ENTRY_DIGITS=3
- Sub-module bcd_entry_shift: 3-digit shift register with clear, digit validity check, and outputs nonzero and sec_tens_ok.
- Top level: FSM, DONE_CYCLES down-counter, output decode.

## Test plan
- Reset, then keys 1,3,0, door closed, start → load pulses one cycle with load_digits=12'h130. magnetron_on=1 from the next cycle, and count_enablen=0 only on tick cycles.
- Keys 9,9 then start → rejected (sec_tens=9). State stays ENTRY, load never asserts.
- Cooking with 0:05: door opens after 2 ticks → magnetron_on=0 and count_enablen held 1. Door closes, then start → resume with load=0, no reload.
- Cooking: force timer_zero=1 → done high for exactly DONE_CYCLES (4) cycles, then IDLE with entry=0.
- Keys 1,2,3,4 → load_digits=12'h234. stop_clear with start in the same cycle → IDLE, entry=0.
- rst=0 asserted mid-COOK → next edge: IDLE, magnetron_on=0, load=0, done=0, count_enablen=1.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and limits for the microwave timer control path.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         ENTRY_DIGITS = 3;

endpackage

// File: rtl/bcd_entry_shift.sv
// Keypad entry register: shifts valid BCD digits in from the right, oldest
// digit falls off the left. Flags whether the entry is nonzero and whether
// the seconds-tens digit is a legal 0..5.
module bcd_entry_shift
  import microwave_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic                      clr,
  input  logic [3:0]                digit,
  output logic [ENTRY_DIGITS*4-1:0] digits,
  output logic                      digit_ok,
  output logic                      nonzero,
  output logic                      sec_tens_ok
);

  localparam int W = ENTRY_DIGITS * 4;

  logic [W-1:0] entry_q, entry_d;

  assign digit_ok = (digit <= BCD_MAX);

  // Next entry value: clear wins over shift; invalid digits never enter.
  always_comb begin
    entry_d = entry_q;
    if (clr)
      entry_d = '0;
    else if (shift_en && digit_ok)
      entry_d = {entry_q[W-5:0], digit};
  end

  // Entry register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) entry_q <= '0;
    else      entry_q <= entry_d;
  end

  assign digits      = entry_q;
  assign nonzero     = |entry_q;
  assign sec_tens_ok = (entry_q[7:4] <= SEC_TENS_MAX);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Oven timer sequencer: collects keypad entry, loads the BCD down-counter
// chain on start, gates the 1 Hz count enable while cooking, and holds
// done for DONE_CYCLES cycles once the chain reaches zero.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int DONE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  input  logic        tick,
  input  logic        timer_zero,
  output logic        load,
  output logic [11:0] load_digits,
  output logic        count_enablen,
  output logic        magnetron_on,
  output logic        done
);

  localparam int              CW        = $clog2(DONE_CYCLES + 1);
  localparam logic [CW-1:0]   DONE_LAST = CW'(DONE_CYCLES - 1);

  state_e        state_q, state_d;
  logic          load_q, load_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;

  logic ent_shift, ent_clr;
  logic digit_ok, nonzero, sec_tens_ok;
  logic key_ok;

  // A key only counts when no higher-priority strobe shares its cycle.
  assign key_ok = key_valid && !start && !stop_clear;

  bcd_entry_shift u_entry (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (ent_shift),
    .clr         (ent_clr),
    .digit       (key_digit),
    .digits      (load_digits),
    .digit_ok    (digit_ok),
    .nonzero     (nonzero),
    .sec_tens_ok (sec_tens_ok)
  );

  // Next-state, entry control and done countdown.
  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    done_cnt_d = done_cnt_q;
    ent_shift  = 1'b0;
    ent_clr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_ok && digit_ok) begin
          ent_shift = 1'b1;
          state_d   = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (stop_clear) begin
          ent_clr = 1'b1;
          state_d = S_IDLE;
        end else if (start) begin
          // Rejected starts (door open, 0:00, bad seconds) are silent no-ops.
          if (door_closed && nonzero && sec_tens_ok) begin
            state_d = S_COOK;
            load_d  = 1'b1;
          end
        end else if (key_ok) begin
          ent_shift = 1'b1;
        end
      end
      S_COOK: begin
        // timer_zero during the load cycle still reflects the old count.
        if (stop_clear || !door_closed) begin
          state_d = S_PAUSE;
        end else if (timer_zero && !load_q) begin
          state_d    = S_DONE;
          done_cnt_d = DONE_LAST;
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          ent_clr = 1'b1;
          state_d = S_IDLE;
        end else if (start && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_clear || done_cnt_q == '0) begin
          ent_clr = 1'b1;
          state_d = S_IDLE;
        end else begin
          done_cnt_d = done_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      load_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign load          = load_q;
  assign magnetron_on  = (state_q == S_COOK);
  assign done          = (state_q == S_DONE);
  assign count_enablen = !((state_q == S_COOK) && tick && !load_q);

endmodule
